// File: rtl/ifft_ram_buf.sv
// ifft_ram_buf: captures one 2^AW-beat IFFT frame into a simple dual-port RAM, then streams it out.
// Latency: first output word is valid 2 cycles after the last input beat; drain sustains 1 beat/cycle.
// Backpressure: upstream ready only while filling; downstream stalls hold data/valid stable.
// Optional macro IFFT_TLAST_CHK_EN enables the sticky tlast framing check on frame_err.
module ifft_ram_buf #(
   parameter int DW = 64,
   parameter int AW = 13
) (
   input  logic          clk_dma,
   input  logic          rst,
   input  logic          s_axi_ifft_tvld,
   output logic          s_axi_ifft_trdy,
   input  logic [DW-1:0] s_axi_ifft_tdat,
   input  logic          s_axi_ifft_tlast,
   input  logic          dma_axi_trdy,
   output logic          dma_axi_tvld,
   output logic [DW-1:0] dma_axi_tdat,
   output logic          ram_rdy,
   output logic          frame_err
);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      PRIME = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
   localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
   localparam logic [AW-1:0] ONE_ADDR  = {{(AW-1){1'b0}}, 1'b1};

   state_t        state;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          out_valid;
   logic          in_ready;
   logic          ram_rdy_r;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   logic wr_beat;
   logic wr_last;
   logic dr_beat;
   logic dr_last;
   logic rd_en;

   // Write only while filling; in_ready is already low outside FILL, state gate is belt and braces.
   assign wr_beat = s_axi_ifft_tvld & in_ready & (state == FILL);
   assign wr_last = wr_beat & (wr_addr == LAST_ADDR);

   // rd_addr runs one word ahead of the presented word, so it reads zero only while the final
   // word of the frame is on the output.
   assign dr_beat = (state == DRAIN) & out_valid & dma_axi_trdy;
   assign dr_last = dr_beat & (rd_addr == ZERO_ADDR);

   // RAM output register doubles as the output stage: refill when empty or being consumed,
   // but never fetch past the end of the frame.
   assign rd_en = (state == PRIME) |
                  ((state == DRAIN) & (~out_valid | dma_axi_trdy) & (rd_addr != ZERO_ADDR));

   assign s_axi_ifft_trdy = in_ready;
   assign dma_axi_tvld    = out_valid;
   assign dma_axi_tdat    = rd_data;
   assign ram_rdy         = ram_rdy_r;

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk_dma) begin
      if (wr_beat) begin
         mem[wr_addr] <= s_axi_ifft_tdat;
      end
   end

   // RAM synchronous read port; holds its word while the output is stalled.
   always_ff @(posedge clk_dma) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

   // Frame FSM: FILL -> PRIME -> DRAIN -> FILL, with registered handshake outputs.
   always_ff @(posedge clk_dma or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         wr_addr   <= ZERO_ADDR;
         rd_addr   <= ZERO_ADDR;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
         ram_rdy_r <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (wr_beat) begin
                  wr_addr <= wr_addr + ONE_ADDR;
               end
               if (wr_last) begin
                  state    <= PRIME;
                  in_ready <= 1'b0;
               end
            end
            PRIME: begin
               rd_addr   <= rd_addr + ONE_ADDR;
               out_valid <= 1'b1;
               ram_rdy_r <= 1'b1;
               state     <= DRAIN;
            end
            DRAIN: begin
               if (rd_en) begin
                  rd_addr <= rd_addr + ONE_ADDR;
               end
               if (dr_last) begin
                  state     <= FILL;
                  out_valid <= 1'b0;
                  ram_rdy_r <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= FILL;
               out_valid <= 1'b0;
               ram_rdy_r <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

`ifdef IFFT_TLAST_CHK_EN
   // Sticky framing error: tlast must mark exactly the beat written at the last address.
   always_ff @(posedge clk_dma or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else if (wr_beat && (s_axi_ifft_tlast != (wr_addr == LAST_ADDR))) begin
         frame_err <= 1'b1;
      end
   end
`else
   logic tlast_unused;
   assign tlast_unused = s_axi_ifft_tlast;
   assign frame_err    = 1'b0;
`endif

endmodule
